// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a small byte FIFO
//   clk         : system clock, all state updates on its rising edge
//   rst_n       : asynchronous active-low reset, aborts any frame and empties the FIFO
//   send_data   : byte to queue for transmission
//   WE          : one-cycle write strobe that queues send_data
//   UART_TXD    : registered serial line, idle high
//   tx_busy     : FIFO non-empty or a frame in progress
//   tx_full     : FIFO holds FIFO_DEPTH bytes
//   tx_empty    : FIFO holds no bytes
//   tx_done     : one-cycle pulse during the last cycle of each stop bit
//   tx_overflow : sticky, set by a write dropped on a full FIFO; cleared only by reset
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] send_data,
    input  logic       WE,
    output logic       UART_TXD,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_done,
    output logic       tx_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DONE_AT = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic [CW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          bit_end, push, pop;

    assign tx_full  = count == DEPTH_N;
    assign tx_empty = count == '0;
    assign tx_busy  = state != IDLE || !tx_empty;
    assign bit_end  = baud == LAST;
    assign push     = WE && !tx_full;
    // Pop from IDLE, or at the last cycle of a stop bit so the next start bit follows with no gap.
    assign pop      = !tx_empty && (state == IDLE || (state == STOP && bit_end));

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= send_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count       <= count + NW'(push) - NW'(pop);
            tx_overflow <= tx_overflow | (WE & tx_full);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            idx      <= '0;
            shreg    <= '0;
            UART_TXD <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            // Raised one edge early so the pulse covers the final cycle of the stop bit.
            tx_done <= state == STOP && baud == DONE_AT;
            baud    <= (state == IDLE || bit_end) ? '0 : baud + CW'(1);
            if (pop) begin
                state    <= START;
                shreg    <= mem[rd_ptr];
                UART_TXD <= 1'b0;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state    <= DATA;
                        UART_TXD <= shreg[0];
                        shreg    <= shreg >> 1;
                        idx      <= '0;
                    end
                    DATA: begin
                        if (idx == 3'd7) begin
                            state    <= STOP;
                            UART_TXD <= 1'b1;
                        end else begin
                            UART_TXD <= shreg[0];
                            shreg    <= shreg >> 1;
                            idx      <= idx + 3'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        UART_TXD <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLKS_PER_BIT=4 plus one default-parameter frame
module tb_uart_tx;
    localparam int C = 4;

    logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, we2 = 1'b0;
    logic [7:0] data = 8'h00, data2 = 8'h00;
    logic txd, busy, full, empty, done, ovf;
    logic txd2, busy2, full2, empty2, done2, ovf2;
    int applied = 0, miscompares = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .send_data(data), .WE(we), .UART_TXD(txd),
        .tx_busy(busy), .tx_full(full), .tx_empty(empty), .tx_done(done), .tx_overflow(ovf)
    );

    uart_tx dut2 (
        .clk(clk), .rst_n(rst_n), .send_data(data2), .WE(we2), .UART_TXD(txd2),
        .tx_busy(busy2), .tx_full(full2), .tx_empty(empty2), .tx_done(done2), .tx_overflow(ovf2)
    );

    // Line receiver: finds a start bit, samples each bit mid-way, logs bytes, start and done times.
    logic [7:0] rx_q[$];
    int st_q[$], done_q[$];
    logic m_on = 1'b0;
    logic [7:0] m_b = 8'h00;
    int m_t = 0, stop_err = 0;

    always @(negedge clk) begin
        if (!rst_n) m_on = 1'b0;
        else begin
            if (done) done_q.push_back(cyc);
            if (!m_on) begin
                if (!txd) begin
                    m_on = 1'b1;
                    m_t = 0;
                    st_q.push_back(cyc);
                end
            end else begin
                m_t++;
                if (m_t % C == C / 2 && m_t / C >= 1 && m_t / C <= 8) m_b[m_t / C - 1] = txd;
                if (m_t == 9 * C + C / 2) begin
                    if (!txd) stop_err++;
                    rx_q.push_back(m_b);
                end
                if (m_t == 10 * C - 1) m_on = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        data = b;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic clr();
        rx_q.delete();
        st_q.delete();
        done_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        chk({tag, " idle"}, busy, 0);
    endtask

    task automatic expect_rx(input string tag, input int n, input logic [63:0] b);
        chk({tag, " count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++)
            chk({tag, " byte"}, i < rx_q.size() ? 32'(rx_q[i]) : 32'hdead, 32'(b[8*i +: 8]));
    endtask

    function automatic logic fb(input logic [7:0] b, input int i);
        return i == 0 ? 1'b0 : i >= 9 ? 1'b1 : b[i-1];
    endfunction

    initial begin
        logic [3:0] g;
        int dn, errs;

        tick(2);
        chk("rst line", txd, 1);
        chk("rst busy", busy, 0);
        chk("rst full", full, 0);
        chk("rst empty", empty, 1);
        chk("rst done", done, 0);
        chk("rst ovf", ovf, 0);
        chk("rst empty2", empty2, 1);
        rst_n = 1'b1;

        // Single byte 0xA5, written on the first edge after reset release.
        clr();
        wr(8'hA5);
        chk("a5 busy", busy, 1);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < C; j++) begin
                tick();
                g[j] = txd;
                if (i * C + j < 10 * C - 1) dn += int'(done);
            end
            chk("a5 bit", g, fb(8'hA5, i) ? 4'hF : 4'h0);
        end
        chk("a5 early done", dn, 0);
        chk("a5 done", done, 1);
        tick();
        chk("a5 busy end", busy, 0);
        chk("a5 done clr", done, 0);
        chk("a5 idle line", txd, 1);
        expect_rx("a5 rx", 1, 64'hA5);

        // Three back-to-back frames.
        clr();
        wr(8'h00);
        wr(8'hFF);
        wr(8'h55);
        wait_idle("b2b");
        expect_rx("b2b", 3, 64'h55FF00);
        chk("b2b starts", st_q.size(), 3);
        chk("b2b dones", done_q.size(), 3);
        chk("b2b gap1", st_q[1] - st_q[0], 10 * C);
        chk("b2b gap2", st_q[2] - st_q[1], 10 * C);
        chk("b2b done gap1", done_q[1] - done_q[0], 10 * C);
        chk("b2b done gap2", done_q[2] - done_q[1], 10 * C);
        chk("b2b done pos", done_q[0] - st_q[0], 10 * C - 1);

        // Overflow: one frame in flight, four queued, fifth dropped.
        clr();
        wr(8'h11);
        tick(2);
        wr(8'h22);
        wr(8'h33);
        wr(8'h44);
        chk("ovf not full", full, 0);
        wr(8'h55);
        chk("ovf full", full, 1);
        chk("ovf not yet", ovf, 0);
        wr(8'h66);
        chk("ovf set", ovf, 1);
        chk("ovf still full", full, 1);
        wait_idle("ovf");
        expect_rx("ovf", 5, 64'h5544332211);
        chk("ovf sticky", ovf, 1);
        chk("ovf empty", empty, 1);

        // Write coinciding with the stop-bit pop while one byte is queued.
        clr();
        wr(8'hA1);
        wr(8'hB2);
        tick(10 * C - 1);
        chk("wp done align", done, 1);
        wr(8'hC3);
        chk("wp not empty", empty, 0);
        wr(8'hD4);
        wr(8'hE5);
        chk("wp cnt3 not full", full, 0);
        wr(8'hF6);
        chk("wp cnt4 full", full, 1);
        wait_idle("wp");
        expect_rx("wp", 6, 64'hF6E5D4C3B2A1);

        // Reset during the data phase, then a fresh byte.
        clr();
        wr(8'h5A);
        wr(8'h77);
        tick(5);
        chk("pre-rst line", txd, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst line", txd, 1);
        chk("mid-rst empty", empty, 1);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst ovf", ovf, 0);
        chk("mid-rst done", done, 0);
        tick();
        rst_n = 1'b1;
        clr();
        wr(8'h3C);
        wait_idle("post-rst");
        expect_rx("post-rst", 1, 64'h3C);
        chk("stop bits", stop_err, 0);

        // Default parameters: 0x81 at 434 cycles per bit.
        data2 = 8'h81;
        we2 = 1'b1;
        tick();
        we2 = 1'b0;
        errs = 0;
        dn = 0;
        for (int k = 1; k <= 4340; k++) begin
            tick();
            if (txd2 !== fb(8'h81, (k - 1) / 434)) errs++;
            dn += int'(done2);
            if (k == 1) chk("d81 start", txd2, 0);
            if (k == 4340) chk("d81 done", done2, 1);
        end
        chk("d81 bit errors", errs, 0);
        chk("d81 done count", dn, 1);
        tick();
        chk("d81 busy end", busy2, 0);
        chk("d81 line", txd2, 1);
        chk("d81 ovf", ovf2, 0);
        chk("d81 full", full2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
